// File: rtl/bp_be_dcache_ret_fmt.sv
// Load-return formatting stage: extracts the accessed lane from the raw dword,
// sign-extends or NaN-boxes it, and buffers results in a small in-order FIFO.
package bp_be_dcache_ret_fmt_pkg;

  typedef enum logic [0:0] {e_bp_default_cfg = 1'b0} bp_params_e;

  localparam int dcache_tag_width_gp = 3;

  typedef struct packed {
    logic                           byte_op;
    logic                           half_op;
    logic                           word_op;
    logic                           double_op;
    logic                           signed_op;
    logic                           float_op;
    logic                           ptw_op;
    logic                           ret_op;
    logic [4:0]                     rd_addr;
    logic [dcache_tag_width_gp-1:0] tag;
  } bp_be_dcache_decode_s;

  localparam int dcache_decode_width_lp = $bits(bp_be_dcache_decode_s);

  function automatic int dword_width_of(input bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return 64;
      default:          return 64;
    endcase
  endfunction

endpackage

module bp_be_dcache_ret_fmt
  import bp_be_dcache_ret_fmt_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_default_cfg,
  parameter int         els_p       = 2
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic                              v_i,
  output logic                              ready_o,
  input  logic [dcache_decode_width_lp-1:0] decode_i,
  input  logic [2:0]                        offset_i,
  input  logic [dword_width_of(bp_params_p)-1:0] data_i,
  output logic                              v_o,
  input  logic                              yumi_i,
  output logic [dword_width_of(bp_params_p)-1:0] data_o,
  output logic [4:0]                        rd_addr_o,
  output logic [dcache_tag_width_gp-1:0]    tag_o,
  output logic                              float_o,
  output logic                              ptw_o
);

  localparam int dword_width_gp = dword_width_of(bp_params_p);
  localparam int ptr_w          = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w          = $clog2(els_p + 1);

  typedef logic [ptr_w-1:0] ptr_t;
  typedef logic [cnt_w-1:0] cnt_t;

  typedef struct packed {
    logic [dword_width_gp-1:0]      data;
    logic [4:0]                     rd_addr;
    logic [dcache_tag_width_gp-1:0] tag;
    logic                           float_op;
    logic                           ptw_op;
  } entry_s;

  bp_be_dcache_decode_s dec;
  assign dec = bp_be_dcache_decode_s'(decode_i);

  // Lane select uses only the offset bits at or above the access size.
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] word_lane;
  logic        sext;
  logic [dword_width_gp-1:0] fmt_data;

  assign byte_lane = data_i[{offset_i, 3'b000} +: 8];
  assign half_lane = data_i[{offset_i[2:1], 4'b0000} +: 16];
  assign word_lane = data_i[{offset_i[2], 5'b00000} +: 32];
  assign sext      = dec.signed_op & ~dec.float_op;

  always_comb begin
    fmt_data = data_i;
    if (!(dec.ptw_op || dec.double_op)) begin
      if (dec.word_op)
        fmt_data = dec.float_op ? {32'hFFFF_FFFF, word_lane}
                                : {{32{sext & word_lane[31]}}, word_lane};
      else if (dec.half_op)
        fmt_data = {{48{sext & half_lane[15]}}, half_lane};
      else if (dec.byte_op)
        fmt_data = {{56{sext & byte_lane[7]}}, byte_lane};
    end
  end

  // Handshake: input accepted when v_i & ready_o; head consumed when v_o & yumi_i.
  ptr_t   rptr, wptr;
  cnt_t   count;
  logic   enq, deq;
  entry_s mem [els_p];

  assign ready_o = (count != cnt_t'(els_p));
  assign v_o     = (count != '0);
  assign enq     = v_i & ready_o & dec.ret_op;
  assign deq     = yumi_i & v_o;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (enq) wptr <= (wptr == ptr_t'(els_p - 1)) ? '0 : wptr + 1'b1;
      if (deq) rptr <= (rptr == ptr_t'(els_p - 1)) ? '0 : rptr + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset; it is only observed while v_o is high.
  always_ff @(posedge clk_i) begin
    if (enq) mem[wptr] <= '{data: fmt_data, rd_addr: dec.rd_addr, tag: dec.tag,
                            float_op: dec.float_op, ptw_op: dec.ptw_op};
  end

  assign data_o    = mem[rptr].data;
  assign rd_addr_o = mem[rptr].rd_addr;
  assign tag_o     = mem[rptr].tag;
  assign float_o   = mem[rptr].float_op;
  assign ptw_o     = mem[rptr].ptw_op;

endmodule

// File: tb/tb_bp_be_dcache_ret_fmt.sv
// Self-checking bench for bp_be_dcache_ret_fmt: directed lane/extension cases,
// drop path, full back-pressure, async reset mid-stall, and a randomized stream.
module tb_bp_be_dcache_ret_fmt;
  import bp_be_dcache_ret_fmt_pkg::*;

  localparam int ELS = 2;

  typedef struct packed {
    logic [63:0] data;
    logic [4:0]  rd;
    logic [2:0]  tag;
    logic        fl;
    logic        ptw;
  } model_s;

  // Clock/reset
  logic clk = 1'b0;
  logic reset_i = 1'b1;
  always #5 clk = ~clk;

  logic                              v_i = 1'b0;
  logic                              ready_o;
  logic [dcache_decode_width_lp-1:0] decode_i = '0;
  logic [2:0]                        offset_i = '0;
  logic [63:0]                       data_i = '0;
  logic                              v_o;
  logic                              yumi_i = 1'b0;
  logic [63:0]                       data_o;
  logic [4:0]                        rd_addr_o;
  logic [2:0]                        tag_o;
  logic                              float_o;
  logic                              ptw_o;

  bp_be_dcache_ret_fmt #(.bp_params_p(e_bp_default_cfg), .els_p(ELS)) dut (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .ready_o(ready_o),
    .decode_i(decode_i), .offset_i(offset_i), .data_i(data_i),
    .v_o(v_o), .yumi_i(yumi_i), .data_o(data_o), .rd_addr_o(rd_addr_o),
    .tag_o(tag_o), .float_o(float_o), .ptw_o(ptw_o)
  );

  always @(posedge clk)
    if (!reset_i && yumi_i && !v_o) $error("illegal yumi_i without v_o");

  // Scoreboard
  model_s exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  function automatic bp_be_dcache_decode_s mk(input int sz, input bit sgn, input bit flt,
                                              input bit ptw, input bit ret,
                                              input int rd, input int tag);
    bp_be_dcache_decode_s d;
    d = '0;
    d.byte_op   = (sz == 0);
    d.half_op   = (sz == 1);
    d.word_op   = (sz == 2);
    d.double_op = (sz == 3);
    d.signed_op = sgn;
    d.float_op  = flt;
    d.ptw_op    = ptw;
    d.ret_op    = ret;
    d.rd_addr   = 5'(rd);
    d.tag       = 3'(tag);
    return d;
  endfunction

  // Reference formatting: shift the naturally aligned lane down, mask, then extend.
  function automatic logic [63:0] fmt(input bp_be_dcache_decode_s d, input logic [2:0] off,
                                      input logic [63:0] data);
    int n, lane;
    logic [63:0] v, mask;
    n = d.byte_op ? 1 : d.half_op ? 2 : d.word_op ? 4 : 8;
    if (d.ptw_op || n == 8) return data;
    lane = (int'(off) / n) * n;
    v = data >> (8 * lane);
    mask = (64'd1 << (8 * n)) - 64'd1;
    v = v & mask;
    if (d.float_op && n == 4) return {32'hFFFF_FFFF, v[31:0]};
    if (d.signed_op && !d.float_op && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  // Driver: one clock with the given inputs; updates the model at the edge.
  task automatic cycle(input logic v, input logic y, input bp_be_dcache_decode_s d,
                       input logic [2:0] off, input logic [63:0] dat);
    bit acc, pop;
    v_i = v; yumi_i = y; decode_i = d; offset_i = off; data_i = dat;
    @(posedge clk);
    acc = v && (exp_q.size() < ELS);
    pop = y && (exp_q.size() > 0);
    if (pop) void'(exp_q.pop_front());
    if (acc && d.ret_op) exp_q.push_back('{data: fmt(d, off, dat), rd: d.rd_addr,
                                           tag: d.tag, fl: d.float_op, ptw: d.ptw_op});
    #1;
    v_i = 1'b0; yumi_i = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < ELS + 1; i++) cycle(1'b0, v_o, '0, 3'd0, 64'd0);
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    n_vec++; if (v_o !== 1'b0) begin n_err++; $display("FAIL reset_v_o: got %b expected 0", v_o); end
    n_vec++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", ready_o); end
    @(negedge clk); reset_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_signed_byte();
    cycle(1'b1, 1'b0, mk(0, 1, 0, 0, 1, 3, 1), 3'd3, 64'h0000_0000_8000_0000);
    n_vec++; if (v_o !== 1'b1) begin n_err++; $display("FAIL lb_v_o: got %b expected 1", v_o); end
    n_vec++; if (data_o !== 64'hFFFF_FFFF_FFFF_FF80) begin n_err++; $display("FAIL lb_data: got %h expected %h", data_o, 64'hFFFF_FFFF_FFFF_FF80); end
    cycle(1'b1, 1'b1, mk(0, 0, 0, 0, 1, 4, 1), 3'd3, 64'h0000_0000_8000_0000);
    n_vec++; if (data_o !== 64'h80) begin n_err++; $display("FAIL lbu_data: got %h expected %h", data_o, 64'h80); end
    n_vec++; if (rd_addr_o !== 5'd4) begin n_err++; $display("FAIL lbu_rd: got %0d expected 4", rd_addr_o); end
    drain();
    n_vec++; if (v_o !== 1'b0) begin n_err++; $display("FAIL lb_drain_v_o: got %b expected 0", v_o); end
  endtask

  task automatic test_lanes();
    logic [63:0] d = 64'h1234_5678_9ABC_DEF0;
    cycle(1'b1, v_o, mk(1, 0, 0, 0, 1, 1, 0), 3'd6, d);
    n_vec++; if (data_o !== 64'h1234) begin n_err++; $display("FAIL lhu_off6: got %h expected %h", data_o, 64'h1234); end
    cycle(1'b1, v_o, mk(1, 1, 0, 0, 1, 2, 0), 3'd2, d);
    n_vec++; if (data_o !== 64'hFFFF_FFFF_FFFF_9ABC) begin n_err++; $display("FAIL lh_off2: got %h expected %h", data_o, 64'hFFFF_FFFF_FFFF_9ABC); end
    cycle(1'b1, v_o, mk(2, 0, 0, 0, 1, 3, 0), 3'd4, d);
    n_vec++; if (data_o !== 64'h1234_5678) begin n_err++; $display("FAIL lwu_off4: got %h expected %h", data_o, 64'h1234_5678); end
    drain();
  endtask

  task automatic test_fp_raw();
    logic [63:0] d = 64'hDEAD_BEEF_3F80_0000;
    cycle(1'b1, v_o, mk(2, 0, 1, 0, 1, 7, 2), 3'd0, d);
    n_vec++; if (data_o !== 64'hFFFF_FFFF_3F80_0000) begin n_err++; $display("FAIL flw_data: got %h expected %h", data_o, 64'hFFFF_FFFF_3F80_0000); end
    n_vec++; if (float_o !== 1'b1) begin n_err++; $display("FAIL flw_float: got %b expected 1", float_o); end
    cycle(1'b1, v_o, mk(3, 1, 1, 0, 1, 8, 2), 3'd0, d);
    n_vec++; if (data_o !== d) begin n_err++; $display("FAIL fld_data: got %h expected %h", data_o, d); end
    cycle(1'b1, v_o, mk(3, 0, 0, 1, 1, 0, 5), 3'd0, 64'h8000_0000_0000_1001);
    n_vec++; if (data_o !== 64'h8000_0000_0000_1001) begin n_err++; $display("FAIL ptw_data: got %h expected %h", data_o, 64'h8000_0000_0000_1001); end
    n_vec++; if (ptw_o !== 1'b1 || tag_o !== 3'd5) begin n_err++; $display("FAIL ptw_flags: got ptw=%b tag=%0d expected ptw=1 tag=5", ptw_o, tag_o); end
    drain();
  endtask

  task automatic test_drop();
    cycle(1'b1, 1'b0, mk(3, 0, 0, 0, 0, 9, 0), 3'd0, 64'h55);
    n_vec++; if (v_o !== 1'b0 || ready_o !== 1'b1) begin n_err++; $display("FAIL drop_sd: got v_o=%b ready=%b expected 0/1", v_o, ready_o); end
    cycle(1'b1, 1'b0, mk(3, 0, 0, 0, 0, 0, 0), 3'd0, 64'h66);
    n_vec++; if (v_o !== 1'b0 || ready_o !== 1'b1) begin n_err++; $display("FAIL drop_ld_x0: got v_o=%b ready=%b expected 0/1", v_o, ready_o); end
    cycle(1'b1, 1'b0, mk(3, 0, 0, 0, 1, 5, 0), 3'd0, 64'h77);
    n_vec++; if (v_o !== 1'b1 || rd_addr_o !== 5'd5) begin n_err++; $display("FAIL drop_ld_x5: got v_o=%b rd=%0d expected 1/5", v_o, rd_addr_o); end
    drain();
  endtask

  task automatic test_full();
    bp_be_dcache_decode_s ld = mk(3, 0, 0, 0, 1, 10, 0);
    cycle(1'b1, 1'b0, ld, 3'd0, 64'hAAAA);
    cycle(1'b1, 1'b0, ld, 3'd0, 64'hBBBB);
    n_vec++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL full_ready: got %b expected 0", ready_o); end
    cycle(1'b1, 1'b0, ld, 3'd0, 64'hCCCC);
    n_vec++; if (ready_o !== 1'b0 || data_o !== 64'hAAAA) begin n_err++; $display("FAIL full_ignore: got ready=%b data=%h expected 0/aaaa", ready_o, data_o); end
    cycle(1'b1, 1'b1, ld, 3'd0, 64'hCCCC);
    n_vec++; if (ready_o !== 1'b1 || data_o !== 64'hBBBB) begin n_err++; $display("FAIL full_pop1: got ready=%b data=%h expected 1/bbbb", ready_o, data_o); end
    cycle(1'b1, 1'b1, ld, 3'd0, 64'hCCCC);
    n_vec++; if (v_o !== 1'b1 || data_o !== 64'hCCCC) begin n_err++; $display("FAIL full_third: got v_o=%b data=%h expected 1/cccc", v_o, data_o); end
    cycle(1'b0, 1'b1, ld, 3'd0, 64'h0);
    n_vec++; if (v_o !== 1'b0) begin n_err++; $display("FAIL full_empty: got %b expected 0", v_o); end
  endtask

  task automatic test_reset_mid();
    bp_be_dcache_decode_s ld = mk(3, 0, 0, 0, 1, 11, 0);
    cycle(1'b1, 1'b0, ld, 3'd0, 64'h1111);
    cycle(1'b1, 1'b0, ld, 3'd0, 64'h2222);
    #2 reset_i = 1'b1;
    #1;
    exp_q.delete();
    n_vec++; if (v_o !== 1'b0 || ready_o !== 1'b1) begin n_err++; $display("FAIL midreset: got v_o=%b ready=%b expected 0/1", v_o, ready_o); end
    #1 reset_i = 1'b0;
    @(posedge clk); #1;
    cycle(1'b1, 1'b0, ld, 3'd0, 64'h3333);
    n_vec++; if (v_o !== 1'b1 || data_o !== 64'h3333) begin n_err++; $display("FAIL postreset_ld: got v_o=%b data=%h expected 1/3333", v_o, data_o); end
    cycle(1'b1, 1'b0, ld, 3'd0, 64'h4444);
    cycle(1'b0, 1'b1, ld, 3'd0, 64'h0);
    n_vec++; if (data_o !== 64'h4444) begin n_err++; $display("FAIL postreset_order: got %h expected 4444", data_o); end
    drain();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 24; i++) begin
      cycle(1'b1, v_o, mk($urandom_range(0, 3), 1'($urandom), 1'b0, 1'b0, 1'b1,
                          $urandom_range(1, 31), $urandom_range(0, 7)),
            3'($urandom), {$urandom, $urandom});
      n_vec++;
      if (v_o !== 1'b1 || ready_o !== 1'b1 || exp_q.size() != 1 ||
          {data_o, rd_addr_o, tag_o, float_o, ptw_o} !== exp_q[0]) begin
        n_err++;
        $display("FAIL b2b[%0d]: got v=%b rdy=%b data=%h expected v=1 rdy=1 data=%h",
                 i, v_o, ready_o, data_o, exp_q.size() > 0 ? exp_q[0].data : 64'h0);
      end
    end
    drain();
  endtask

  task automatic test_random();
    bp_be_dcache_decode_s d;
    for (int i = 0; i < 400; i++) begin
      d = mk($urandom_range(0, 3), 1'($urandom), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) != 0),
             $urandom_range(0, 31), $urandom_range(0, 7));
      cycle(1'($urandom), v_o & ($urandom_range(0, 2) != 0), d, 3'($urandom), {$urandom, $urandom});
      n_vec++;
      if (v_o !== (exp_q.size() != 0) || ready_o !== (exp_q.size() < ELS)) begin
        n_err++;
        $display("FAIL rand_flags[%0d]: got v=%b rdy=%b expected v=%b rdy=%b",
                 i, v_o, ready_o, exp_q.size() != 0, exp_q.size() < ELS);
      end
      if (exp_q.size() != 0) begin
        n_vec++;
        if ({data_o, rd_addr_o, tag_o, float_o, ptw_o} !== exp_q[0]) begin
          n_err++;
          $display("FAIL rand_head[%0d]: got %h/%0d/%0d/%b/%b expected %h/%0d/%0d/%b/%b",
                   i, data_o, rd_addr_o, tag_o, float_o, ptw_o, exp_q[0].data,
                   exp_q[0].rd, exp_q[0].tag, exp_q[0].fl, exp_q[0].ptw);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_signed_byte();
    test_lanes();
    test_fp_raw();
    test_drop();
    test_full();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
